// File: rtl/drum_pkg.sv
// Shared definitions for the pipelined DRUM approximate multiplier.
// Optional feature macro: DRUM_SIGNED_EN (two's complement operands).
package drum_pkg;

   // Smallest legal DRUM window width.
   localparam int unsigned DRUM_MIN_K = 3;

   // Width of the summed shift amount: each operand shift fits in clog2(n) bits,
   // so the sum of two needs one extra bit.
   function automatic int unsigned shift_width(int unsigned n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/drum_operand_encode.sv
// Leading-one detect, window select and shift amount for one DRUM operand.
// Purely combinational; instantiated once per operand in stage S1.
module drum_operand_encode #(
   parameter int unsigned N = 16,
   parameter int unsigned K = 4
) (
   input  logic [N-1:0]         x,
   output logic [K-1:0]         win,
   output logic [$clog2(N)-1:0] shift
);

   localparam int unsigned LW = $clog2(N);

   logic [LW-1:0] lead;

   // Priority-encode the leading one, then pick the K-bit window below it.
   always_comb begin
      lead  = '0;
      win   = x[K-1:0];
      shift = '0;
      for (int i = 0; i < N; i++) begin
         if (x[i]) lead = LW'(i);
      end
      // Small operands (and zero) pass through exactly.
      if (lead > LW'(K - 1)) begin
         shift = lead - LW'(K - 1);
         // Top window bit is the leading one; LSB forced to 1 to unbias truncation.
         win   = K'(x >> shift) | K'(1);
      end
   end

endmodule

// File: rtl/drum_mult_pipe.sv
// Three-stage pipelined DRUM approximate multiplier with valid/ready and tag.
// Optional feature macro: DRUM_SIGNED_EN (two's complement operands).
module drum_mult_pipe
   import drum_pkg::*;
#(
   parameter int unsigned N     = 16,
   parameter int unsigned K     = 4,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_a,
   input  logic [N-1:0]     in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   out_r,
   output logic [TAG_W-1:0] out_tag
);

   localparam int unsigned SW = shift_width(N);
   localparam int unsigned EW = $clog2(N);
   localparam int unsigned PW = 2 * K;
   localparam int unsigned RW = 2 * N;

   if (K < DRUM_MIN_K || K >= N) begin : g_bad_k
      $error("drum_mult_pipe: K must satisfy 3 <= K < N");
   end

   // Stage types depend on module parameters, so they live here.
   typedef struct packed {
      logic             valid;
      logic [K-1:0]     win_a;
      logic [K-1:0]     win_b;
      logic [EW-1:0]    shift_a;
      logic [EW-1:0]    shift_b;
      logic [TAG_W-1:0] tag;
`ifdef DRUM_SIGNED_EN
      logic             sign;
`endif
   } s1_t;

   typedef struct packed {
      logic             valid;
      logic [PW-1:0]    prod;
      logic [SW-1:0]    ssum;
      logic [TAG_W-1:0] tag;
`ifdef DRUM_SIGNED_EN
      logic             sign;
`endif
   } s2_t;

   s1_t           s1_q;
   s2_t           s2_q;
   logic          en;
   logic          accept;
   logic [N-1:0]  mag_a;
   logic [N-1:0]  mag_b;
   logic [K-1:0]  win_a;
   logic [K-1:0]  win_b;
   logic [EW-1:0] shift_a;
   logic [EW-1:0] shift_b;
   logic [RW-1:0] res;

   assign en       = out_ready | ~out_valid;
   assign in_ready = en & ~rst;
   assign accept   = in_valid & in_ready;

   // Operand magnitudes; -2^(N-1) maps to 2^(N-1), which is valid unsigned.
   always_comb begin
`ifdef DRUM_SIGNED_EN
      mag_a = in_a[N-1] ? -in_a : in_a;
      mag_b = in_b[N-1] ? -in_b : in_b;
`else
      mag_a = in_a;
      mag_b = in_b;
`endif
   end

   drum_operand_encode #(.N(N), .K(K)) u_enc_a (
      .x     (mag_a),
      .win   (win_a),
      .shift (shift_a)
   );

   drum_operand_encode #(.N(N), .K(K)) u_enc_b (
      .x     (mag_b),
      .win   (win_b),
      .shift (shift_b)
   );

   // S1: capture windows, shifts and tag; data held when a bubble enters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
      end else if (en) begin
         s1_q.valid <= accept;
         if (accept) begin
            s1_q.win_a   <= win_a;
            s1_q.win_b   <= win_b;
            s1_q.shift_a <= shift_a;
            s1_q.shift_b <= shift_b;
            s1_q.tag     <= in_tag;
`ifdef DRUM_SIGNED_EN
            s1_q.sign    <= in_a[N-1] ^ in_b[N-1];
`endif
         end
      end
   end

   // S2: KxK window product and combined shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_q <= '0;
      end else if (en) begin
         s2_q.valid <= s1_q.valid;
         if (s1_q.valid) begin
            s2_q.prod <= PW'(s1_q.win_a) * PW'(s1_q.win_b);
            s2_q.ssum <= SW'(s1_q.shift_a) + SW'(s1_q.shift_b);
            s2_q.tag  <= s1_q.tag;
`ifdef DRUM_SIGNED_EN
            s2_q.sign <= s1_q.sign;
`endif
         end
      end
   end

   // Barrel shift back to full scale; cannot overflow 2N bits.
   always_comb begin
      res = RW'(s2_q.prod) << s2_q.ssum;
`ifdef DRUM_SIGNED_EN
      if (s2_q.sign && res != '0) res = -res;
`endif
   end

   // S3: output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_r     <= '0;
         out_tag   <= '0;
      end else if (en) begin
         out_valid <= s2_q.valid;
         if (s2_q.valid) begin
            out_r   <= res;
            out_tag <= s2_q.tag;
         end
      end
   end

endmodule
